store_buffer_unit: RTL and testbench

- Write-side counterpart to the immediate/load extension path: narrows 32-bit register data to byte/halfword/word stores.
- Lane-aligns the data and generates byte enables.
- Queues stores in a small FIFO and drains them to data memory over a req/ack handshake.
- Sits between the MEM pipeline stage and the data-memory port; stalls the pipeline when full and flags load-address hazards.

---
 rtl/mips_mem_pkg.sv | 14 +
 rtl/store_lane_align.sv | 49 ++++
 rtl/store_buffer_unit.sv | 126 ++++++++++++
 tb/tb_store_buffer_unit.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared memory-side definitions: store size encodings and lane geometry.
package mips_mem_pkg;

  localparam int BE_W       = 4;
  localparam int WORD_SHIFT = 2;

  typedef enum logic [1:0] {
    SZ_BYTE    = 2'b00,
    SZ_HALF    = 2'b01,
    SZ_WORD    = 2'b10,
    SZ_ILLEGAL = 2'b11
  } memSize_e;

endpackage

// File: rtl/store_lane_align.sv
// Store lane alignment: narrows register data to byte/half/word, replicates it
// across the lanes and produces byte enables plus a misalignment/illegal flag.
// Lane mapping is little-endian unless STORE_BIG_ENDIAN_EN is defined.
module store_lane_align
  import mips_mem_pkg::*;
(
  input  logic [1:0]      size,
  input  logic [1:0]      addr,
  input  logic [31:0]     data,
  output logic [BE_W-1:0] be,
  output logic [31:0]     wdata,
  output logic            err
);

  // Size decode: lane enables, replicated data and alignment check
  always_comb begin
    be    = '0;
    wdata = '0;
    err   = 1'b0;
    case (memSize_e'(size))
      SZ_BYTE: begin
        wdata = {4{data[7:0]}};
`ifdef STORE_BIG_ENDIAN_EN
        be = 4'b1000 >> addr;
`else
        be = 4'b0001 << addr;
`endif
      end
      SZ_HALF: begin
        wdata = {2{data[15:0]}};
        err   = addr[0];
`ifdef STORE_BIG_ENDIAN_EN
        be = addr[1] ? 4'b0011 : 4'b1100;
`else
        be = addr[1] ? 4'b1100 : 4'b0011;
`endif
      end
      SZ_WORD: begin
        wdata = data;
        be    = '1;
        err   = (addr != 2'b00);
      end
      default: begin
        err = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/store_buffer_unit.sv
// Store buffer: aligns MEM-stage stores, queues them in a DEPTH-entry FIFO and
// drains the head to data memory over mem_req/mem_ack. Stalls the pipeline when
// full and flags loads that hit a buffered word.
// Optional: STORE_BIG_ENDIAN_EN selects big-endian lane mapping (in store_lane_align).
module store_buffer_unit
  import mips_mem_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              st_valid,
  input  logic [1:0]        st_size,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [31:0]       st_data,
  output logic              st_stall,
  output logic              st_err,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              ld_hazard,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [BE_W-1:0]   mem_be,
  input  logic              mem_ack,
  output logic              buf_empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int WA_W  = ADDR_W - WORD_SHIFT;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [WA_W-1:0]   entWordAddr [DEPTH];
  logic [31:0]       entData     [DEPTH];
  logic [BE_W-1:0]   entBe       [DEPTH];
  logic [DEPTH-1:0]  entValid;
  logic [PTR_W-1:0]  headPtr;
  logic [PTR_W-1:0]  tailPtr;
  logic [CNT_W-1:0]  count;

  logic [BE_W-1:0]   alignBe;
  logic [31:0]       alignData;
  logic              alignErr;
  logic              isFull;
  logic              isEmpty;
  logic              doPush;
  logic              doPop;
  logic [ADDR_W-1:0] ldWord;

  store_lane_align uAlign (
    .size  (st_size),
    .addr  (st_addr[1:0]),
    .data  (st_data),
    .be    (alignBe),
    .wdata (alignData),
    .err   (alignErr)
  );

  assign isFull    = (count == CNT_FULL);
  assign isEmpty   = (count == '0);
  assign st_err    = st_valid && alignErr;
  assign st_stall  = st_valid && !alignErr && isFull;
  assign doPush    = st_valid && !alignErr && !isFull;
  assign doPop     = !isEmpty && mem_ack;
  assign buf_empty = isEmpty;
  assign mem_req   = !isEmpty;
  assign ldWord    = ld_addr >> WORD_SHIFT;

  // FIFO storage, pointers and occupancy; a full buffer never accepts, even on a pop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      headPtr  <= '0;
      tailPtr  <= '0;
      count    <= '0;
      entValid <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        entWordAddr[i] <= '0;
        entData[i]     <= '0;
        entBe[i]       <= '0;
      end
    end else begin
      if (doPop) begin
        entValid[headPtr] <= 1'b0;
        headPtr           <= headPtr + PTR_ONE;
      end
      if (doPush) begin
        entWordAddr[tailPtr] <= st_addr[ADDR_W-1:WORD_SHIFT];
        entData[tailPtr]     <= alignData;
        entBe[tailPtr]       <= alignBe;
        entValid[tailPtr]    <= 1'b1;
        tailPtr              <= tailPtr + PTR_ONE;
      end
      case ({doPush, doPop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Head entry drives the memory port; all-zero while empty
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (!isEmpty) begin
      mem_addr  = {entWordAddr[headPtr], {WORD_SHIFT{1'b0}}};
      mem_wdata = entData[headPtr];
      mem_be    = entBe[headPtr];
    end
  end

  // Load hazard: any stored entry in the same word as the load
  always_comb begin
    ld_hazard = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (entValid[i] && ({{WORD_SHIFT{1'b0}}, entWordAddr[i]} == ldWord))
        ld_hazard = 1'b1;
    end
  end

endmodule

// File: tb/tb_store_buffer_unit.sv
// Scoreboard bench for store_buffer_unit: directed cases then random traffic,
// checked against a queue-based reference model. Honours STORE_BIG_ENDIAN_EN.
module tb_store_buffer_unit;

  localparam int DEPTH = 2;

  typedef struct {
    logic [29:0] wa;
    logic [31:0] wd;
    logic [3:0]  be;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        st_valid = 1'b0;
  logic [1:0]  st_size = '0;
  logic [31:0] st_addr = '0;
  logic [31:0] st_data = '0;
  logic        st_stall;
  logic        st_err;
  logic [31:0] ld_addr = '0;
  logic        ld_hazard;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic        buf_empty;

  int total = 0;
  int bad   = 0;

  ent_t model[$];
  ent_t sb[$];

  store_buffer_unit #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .st_valid  (st_valid),
    .st_size   (st_size),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .st_stall  (st_stall),
    .st_err    (st_err),
    .ld_addr   (ld_addr),
    .ld_hazard (ld_hazard),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_ack   (mem_ack),
    .buf_empty (buf_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: a store of 2^sz bytes at offset k occupies lanes k..k+n-1 (LE)
  function automatic void refAlign(input logic [1:0] sz, input logic [1:0] k,
                                   input logic [31:0] d, output logic err,
                                   output logic [3:0] be, output logic [31:0] wd);
    int n;
    int mask;
    err = (sz == 2'd3) || (sz == 2'd1 && k[0]) || (sz == 2'd2 && k != 2'd0);
    n = 1 << sz;
    mask = (1 << n) - 1;
`ifdef STORE_BIG_ENDIAN_EN
    be = 4'(mask << (4 - n - int'(k)));
`else
    be = 4'(mask << k);
`endif
    if (sz == 2'd0)      wd = {24'h0, d[7:0]} * 32'h0101_0101;
    else if (sz == 2'd1) wd = {16'h0, d[15:0]} * 32'h0001_0001;
    else                 wd = d;
    if (err) be = '0;
  endfunction

  // One pipeline cycle: drive, check combinational outputs, update the model at the edge
  task automatic cycle(input logic v, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] d, input logic ack, input logic [31:0] ld);
    logic        eErr;
    logic [3:0]  eBe;
    logic [31:0] eWd;
    logic        eHaz;
    logic        push;
    logic        pop;
    ent_t        e;
    @(negedge clk);
    #1;
    st_valid = v; st_size = sz; st_addr = a; st_data = d; mem_ack = ack; ld_addr = ld;
    #2;
    refAlign(sz, a[1:0], d, eErr, eBe, eWd);
    eHaz = 1'b0;
    foreach (model[i]) if (model[i].wa == ld[31:2]) eHaz = 1'b1;
    push = v && !eErr && (model.size() < DEPTH);
    pop  = (model.size() != 0) && ack;
    chk("st_err", 32'(st_err), 32'(v && eErr));
    chk("st_stall", 32'(st_stall), 32'(v && !eErr && model.size() == DEPTH));
    chk("ld_hazard", 32'(ld_hazard), 32'(eHaz));
    e.wa = a[31:2]; e.wd = eWd; e.be = eBe;
    @(posedge clk);
    if (pop) void'(model.pop_front());
    if (push) begin
      model.push_back(e);
      sb.push_back(e);
    end
  endtask

  // Monitor: compares the memory port against the scoreboard head, pops on handshake
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (reset) continue;
      chk("mem_req", 32'(mem_req), 32'(sb.size() != 0));
      chk("buf_empty", 32'(buf_empty), 32'(sb.size() == 0));
      if (sb.size() != 0) begin
        chk("mem_addr", mem_addr, {sb[0].wa, 2'b00});
        chk("mem_wdata", mem_wdata, sb[0].wd);
        chk("mem_be", 32'(mem_be), 32'(sb[0].be));
        if (mem_req && mem_ack) void'(sb.pop_front());
      end else begin
        chk("idle_port", mem_addr | mem_wdata | 32'(mem_be), 32'h0);
      end
    end
  end

  initial begin
    #2;
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_buf_empty", 32'(buf_empty), 32'h1);
    chk("rst_port", mem_addr | mem_wdata | 32'(mem_be), 32'h0);
    chk("rst_ld_hazard", 32'(ld_hazard), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Byte store with ack tied high
    cycle(1, 2'd0, 32'h1003, 32'h0000_00AB, 1, 32'h0);
    #3;
    chk("byte_req", 32'(mem_req), 32'h1);
    chk("byte_addr", mem_addr, 32'h1000);
`ifdef STORE_BIG_ENDIAN_EN
    chk("byte_be", 32'(mem_be), 32'h1);
`else
    chk("byte_be", 32'(mem_be), 32'h8);
`endif
    chk("byte_wdata", mem_wdata, 32'hABAB_ABAB);
    cycle(0, 2'd0, 32'h0, 32'h0, 1, 32'h0);
    #3;
    chk("byte_drained", 32'(buf_empty), 32'h1);

    // Half store, then two misaligned stores that must be dropped
    cycle(1, 2'd1, 32'h2002, 32'h0000_1234, 0, 32'h0);
    cycle(1, 2'd1, 32'h2001, 32'h0000_5678, 0, 32'h0);
    cycle(1, 2'd2, 32'h2006, 32'hDEAD_BEEF, 0, 32'h0);
    #3;
`ifdef STORE_BIG_ENDIAN_EN
    chk("half_be", 32'(mem_be), 32'h3);
`else
    chk("half_be", 32'(mem_be), 32'hC);
`endif
    chk("half_wdata", mem_wdata, 32'h1234_1234);
    cycle(0, 2'd0, 32'h0, 32'h0, 1, 32'h0);

    // Fill to DEPTH, hold C under stall (also across an ack), then accept it
    cycle(1, 2'd2, 32'h4000, 32'hAAAA_0001, 0, 32'h0);
    cycle(1, 2'd2, 32'h4004, 32'hBBBB_0002, 0, 32'h0);
    cycle(1, 2'd2, 32'h4008, 32'hCCCC_0003, 0, 32'h0);
    cycle(1, 2'd2, 32'h4008, 32'hCCCC_0003, 1, 32'h0);
    cycle(1, 2'd2, 32'h4008, 32'hCCCC_0003, 0, 32'h0);
    repeat (3) cycle(0, 2'd0, 32'h0, 32'h0, 1, 32'h0);

    // Load hazard on the same word, none on the next word
    cycle(1, 2'd2, 32'h3008, 32'h1111_2222, 0, 32'h0);
    cycle(0, 2'd0, 32'h0, 32'h0, 0, 32'h300B);
    cycle(0, 2'd0, 32'h0, 32'h0, 0, 32'h300C);

    // One pending: push and pop together, new entry becomes head
    cycle(1, 2'd0, 32'h5001, 32'h0000_0077, 1, 32'h5000);
    #3;
    chk("pp_addr", mem_addr, 32'h5000);
    cycle(0, 2'd0, 32'h0, 32'h0, 1, 32'h0);

    // Reset with two entries pending
    cycle(1, 2'd2, 32'h6000, 32'h0000_0006, 0, 32'h0);
    cycle(1, 2'd2, 32'h6004, 32'h0000_0007, 0, 32'h0);
    @(negedge clk);
    #1;
    st_valid = 1'b0; mem_ack = 1'b0;
    #4;
    reset = 1'b1;
    #1;
    chk("rst_mid_req", 32'(mem_req), 32'h0);
    chk("rst_mid_empty", 32'(buf_empty), 32'h1);
    model.delete();
    sb.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) cycle(0, 2'd0, 32'h0, 32'h0, 1, 32'h0);

    // Random traffic in a small window so hazards and stalls occur
    for (int n = 0; n < 400; n++) begin
      cycle(($urandom_range(0, 9) < 7), 2'($urandom_range(0, 3)),
            32'h3000 + 32'($urandom_range(0, 31)), $urandom,
            ($urandom_range(0, 1) == 1), 32'h3000 + 32'($urandom_range(0, 31)));
    end
    repeat (4) cycle(0, 2'd0, 32'h0, 32'h0, 1, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
